// File: rtl/rx_pkt_fifo_if.sv
// Byte-wide AXI-Stream style link with a frame-error flag on tuser.
// The receive side of rx_pkt_fifo takes the slave view; the committed output takes the master view.
interface rx_pkt_fifo_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tuser;
    logic                  trdy;

    modport master (output tdata, output tvalid, output tlast, output tuser, input trdy);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output trdy);
endinterface

// File: rtl/rx_pkt_fifo.sv
// Store-and-forward receive frame buffer: frames become visible downstream only once
// their last byte arrives clean; errored or overflowing frames are rolled back.
module rx_pkt_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                clk,
    input  logic                reset,
    rx_pkt_fifo_if.slave        s_rx_axis,
    rx_pkt_fifo_if.master       m_axis,
    output logic                frame_good,
    output logic                frame_drop
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PW-1:0] ONE_P   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ACTIVE, DROP} wr_state_t;

    wr_state_t               state;
    logic [DATA_WIDTH:0]     mem [DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           wr_commit;
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           rd_next;
    logic [PW-1:0]           used;
    logic                    rx_trdy;
    logic                    drop_pend;
    logic                    full;
    logic                    beat;
    logic                    rollback;
    logic                    commit;
    logic                    wr_en;
    logic                    pop;
    logic [DATA_WIDTH-1:0]   m_data_p1;
    logic                    m_last_p1;
    logic                    m_vld_p1;

    assign s_rx_axis.trdy = rx_trdy;
    assign m_axis.tdata   = m_data_p1;
    assign m_axis.tlast   = m_last_p1;
    assign m_axis.tvalid  = m_vld_p1;
    assign m_axis.tuser   = 1'b0;

    always_comb begin
        drop_pend = (state == DROP);
        // rd_ptr counts bytes handed downstream, so the byte parked in the
        // output register still occupies its slot until it is taken.
        used      = wr_ptr - rd_ptr;
        full      = (used == DEPTH_P);
        beat      = s_rx_axis.tvalid && rx_trdy;
        rollback  = beat && (s_rx_axis.tuser || (s_rx_axis.tlast && (drop_pend || full)));
        commit    = beat && s_rx_axis.tlast && !s_rx_axis.tuser && !drop_pend && !full;
        wr_en     = beat && !s_rx_axis.tuser && !drop_pend && !full;
        pop       = m_vld_p1 && m_axis.trdy;
        rd_next   = rd_ptr + (pop ? ONE_P : '0);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_rx_axis.tlast, s_rx_axis.tdata};
        end
    end

    // Write side: speculative pointer, commit point and frame state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            wr_commit  <= '0;
            rx_trdy    <= 1'b0;
            frame_good <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            rx_trdy    <= 1'b1;
            frame_good <= commit;
            frame_drop <= rollback;
            if (rollback) begin
                wr_ptr <= wr_commit;
                state  <= IDLE;
            end else if (commit) begin
                wr_ptr    <= wr_ptr + ONE_P;
                wr_commit <= wr_ptr + ONE_P;
                state     <= IDLE;
            end else if (beat) begin
                if (full || drop_pend) begin
                    state <= DROP;
                end else begin
                    wr_ptr <= wr_ptr + ONE_P;
                    state  <= ACTIVE;
                end
            end
        end
    end

    // Read side: show-ahead output register refilled on the cycle it drains
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            m_vld_p1  <= 1'b0;
            m_last_p1 <= 1'b0;
            m_data_p1 <= '0;
        end else begin
            rd_ptr <= rd_next;
            if (!m_vld_p1 || pop) begin
                if (rd_next != wr_commit) begin
                    {m_last_p1, m_data_p1} <= mem[rd_next[ADDR_WIDTH-1:0]];
                    m_vld_p1               <= 1'b1;
                end else begin
                    m_vld_p1 <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/rx_pkt_fifo.md
RX_PKT_FIFO -- requirements
Module: rx_pkt_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, byte width of both AXI-Stream ports.
REQ-002 Parameter ADDR_WIDTH, default 11, log2 of buffer depth; DEPTH = 2^ADDR_WIDTH bytes.
REQ-003 clk  in  1  single clock for all logic; all outputs registered on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 s_rx_axis_tdata  in  DATA_WIDTH  frame byte from rx MAC.
REQ-006 s_rx_axis_tvalid  in  1  byte valid.
REQ-007 s_rx_axis_tlast  in  1  last byte of frame.
REQ-008 s_rx_axis_tuser  in  1  frame error (bad CRC, rgmii_er, dv loss); terminates frame.
REQ-009 s_rx_axis_trdy  out  1  ready to MAC.
REQ-010 m_axis_tdata  out  DATA_WIDTH  committed frame byte.
REQ-011 m_axis_tvalid  out  1  output byte valid.
REQ-012 m_axis_tlast  out  1  last byte of committed frame.
REQ-013 m_axis_trdy  in  1  downstream ready.
REQ-014 frame_good  out  1  one-cycle pulse, frame committed.
REQ-015 frame_drop  out  1  one-cycle pulse, frame discarded.

Function
REQ-016 Store-and-forward: no byte of a frame SHALL appear on m_axis until that frame's tlast is accepted with tuser=0 and no overflow.
REQ-017 Storage SHALL be DEPTH entries of DATA_WIDTH+1 bits (data + last flag), written on each accepted beat (s_rx_axis_tvalid && s_rx_axis_trdy).
REQ-018 Pointers wr_ptr (speculative), wr_commit, rd_ptr SHALL be ADDR_WIDTH+1 bits; addresses use low ADDR_WIDTH bits; wrap modulo 2^(ADDR_WIDTH+1).
REQ-019 Full SHALL be (wr_ptr - rd_ptr) == DEPTH; committed-empty SHALL be rd_ptr == wr_commit.
REQ-020 s_rx_axis_trdy SHALL be 1 whenever reset is deasserted (MAC cannot be stalled mid-frame); overflow is handled by dropping, not backpressure.
REQ-021 Accepted beat while full SHALL not write, SHALL not advance wr_ptr, and SHALL set drop_pend for the remainder of the frame.
REQ-022 Accepted beat with tlast=1, tuser=0, drop_pend=0 SHALL write the byte with last flag=1, set wr_commit <= wr_ptr+1, and pulse frame_good next cycle.
REQ-023 Accepted beat with tuser=1 (tlast either value), or tlast=1 with drop_pend=1, SHALL set wr_ptr <= wr_commit, clear drop_pend, and pulse frame_drop next cycle; that beat SHALL not be written.
REQ-024 The beat following a terminating beat (REQ-022/023) SHALL be treated as first byte of a new frame.
REQ-025 Write-side states: IDLE (no frame open) -> ACTIVE on first accepted beat not terminating; ACTIVE -> DROP on overflow; ACTIVE/DROP -> IDLE on terminating beat; single-beat frame goes IDLE -> IDLE with commit or drop.
REQ-026 Read side SHALL present committed bytes in order with show-ahead output register; m_axis_tvalid held until m_axis_trdy; tdata/tlast stable while tvalid && !trdy.
REQ-027 First byte of a newly committed frame SHALL be on m_axis with tvalid=1 no later than 3 cycles after the commit edge when output was idle.
REQ-028 With m_axis_trdy held high and committed data available, read side SHALL sustain one byte per cycle, including across frame boundaries.
REQ-029 Simultaneous write, commit, rollback and read in the same cycle SHALL all take effect; rollback SHALL never move wr_ptr behind rd_ptr (wr_commit >= rd_ptr invariant).
REQ-030 A frame of exactly DEPTH bytes into an empty buffer SHALL commit; DEPTH+1 bytes SHALL drop.
REQ-031 Freed space from reads SHALL be usable by an in-progress frame in the same cycle's full computation of the next cycle.

Reset
REQ-032 While reset=1: all pointers 0, state IDLE, drop_pend 0, s_rx_axis_trdy 0, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0, frame_good 0, frame_drop 0.
REQ-033 Reset mid-frame SHALL discard all stored and in-progress data; first beat after deassertion starts a new frame.
REQ-034 Memory contents SHALL not require reset.

Verification
REQ-035 64-byte frame 0x00..0x3F, tuser=0, m_axis_trdy=1 -> frame_good pulse, 0x00..0x3F out in order, tlast only on 0x3F, no bytes out before commit.
REQ-036 40-byte frame with tuser=1 on byte 40 -> frame_drop pulse, m_axis_tvalid stays 0, next 10-byte frame 0xA0..0xA9 output intact.
REQ-037 ADDR_WIDTH=6, m_axis_trdy=0: 64-byte frame commits; following 1-byte frame drops (frame_drop pulse); after draining, both pointers equal.
REQ-038 Back-to-back 1-byte frames 0x11, 0x22, 0x33 with m_axis_trdy=1 -> three frame_good pulses, three outputs each with tlast=1.
REQ-039 m_axis_trdy toggled randomly during 100-byte frame readout -> data/tlast stable while stalled, byte order unchanged.
REQ-040 reset asserted at byte 20 of a frame with a prior committed frame unread -> all outputs 0 immediately, no residual bytes out after release.
